// File: rtl/ctrl_rd_capture.sv
// Controller-side read capture stage.
// Waits out the CAS latency after a read command, detects the read preamble
// on dqs_t/dqs_c, assembles one BC4/BL8 burst of dq beats into a word
// (first beat in the LSBs) and hands completed words to the host through a
// small FIFO with a valid/ready handshake. Read commands that arrive while a
// burst is in flight are queued as a count and reuse the latched settings.
module ctrl_rd_capture #(
  parameter int DQ_W       = 8,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int MAX_PEND   = 3
) (
  input  logic              CK_t,
  input  logic              reset,
  input  logic              rd_start,
  input  logic [4:0]        cas_latency,
  input  logic [1:0]        preamble,
  input  logic [3:0]        burst_length,
  input  logic              dqs_t,
  input  logic              dqs_c,
  input  logic [DQ_W-1:0]   dq,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              rd_err,
  output logic              ovf
);

  localparam int BEATS  = DATA_W / DQ_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PW     = PTR_W + 1;
  localparam int TO_W   = $clog2(TIMEOUT);
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CL,
    S_WAIT_PRE,
    S_PRE,
    S_CAPTURE,
    S_PUSH
  } state_e;

  state_e              state_q;
  logic [4:0]          cl_cnt_q;
  logic [1:0]          pre_load_q;   // preamble length minus one
  logic                bl8_q;        // 1: eight beats, 0: BC4
  logic [1:0]          pre_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [DATA_W-1:0]   word_q;
  logic [PEND_W-1:0]   pend_q;
  logic                rd_err_q;
  logic                ovf_q;

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                fifo_full;
  logic                fifo_empty;
  logic                push_en;
  logic                pop_en;
  logic                last_beat;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_en     = !fifo_empty && rd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_en    = (state_q == S_PUSH) && (!fifo_full || pop_en);

  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign busy     = (state_q != S_IDLE) || (pend_q != '0);
  assign rd_err   = rd_err_q;
  assign ovf      = ovf_q;

  // Final beat index of the current burst.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    last_beat = 1'b0;
    if (bl8_q) last_beat = (beat_q == BEAT_W'(BEATS - 1));
    else       last_beat = (beat_q == BEAT_W'(BEATS / 2 - 1));
  end

  // Read-capture FSM with command queue count and registered error pulses.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= S_IDLE;
      cl_cnt_q   <= '0;
      pre_load_q <= '0;
      bl8_q      <= 1'b0;
      pre_cnt_q  <= '0;
      to_cnt_q   <= '0;
      beat_q     <= '0;
      word_q     <= '0;
      pend_q     <= '0;
      rd_err_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_err_q <= 1'b0;
      ovf_q    <= 1'b0;

      // Commands that cannot start now are counted; beyond the limit they are dropped.
      if (rd_start && ((state_q != S_IDLE) || (pend_q != '0))) begin
        if (pend_q < PEND_W'(MAX_PEND)) pend_q <= pend_q + PEND_W'(1);
        else                            rd_err_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (rd_start) begin
            cl_cnt_q   <= cas_latency;
            pre_load_q <= (preamble == 2'd0) ? 2'd0 : preamble - 2'd1;
            bl8_q      <= (burst_length != 4'd4);
            state_q    <= S_WAIT_CL;
          end else if (pend_q != '0) begin
            pend_q   <= pend_q - PEND_W'(1);
            to_cnt_q <= '0;
            state_q  <= S_WAIT_PRE;
          end
        end

        S_WAIT_CL: begin
          cl_cnt_q <= cl_cnt_q - 5'd1;
          // A latency of 0 behaves like 1: one cycle here, then look for the preamble.
          if (cl_cnt_q <= 5'd1) begin
            to_cnt_q <= '0;
            state_q  <= S_WAIT_PRE;
          end
        end

        S_WAIT_PRE: begin
          if (dqs_t && !dqs_c) begin
            pre_cnt_q <= pre_load_q;
            state_q   <= S_PRE;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            rd_err_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        S_PRE: begin
          if (pre_cnt_q == 2'd0) begin
            beat_q  <= '0;
            word_q  <= '0;
            state_q <= S_CAPTURE;
          end else begin
            pre_cnt_q <= pre_cnt_q - 2'd1;
          end
        end

        S_CAPTURE: begin
          word_q[int'(beat_q) * DQ_W +: DQ_W] <= dq;
          beat_q <= beat_q + BEAT_W'(1);
          if (last_beat) state_q <= S_PUSH;
        end

        S_PUSH: begin
          ovf_q   <= fifo_full && !pop_en;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Next FIFO pointers; the wrap bit separates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // FIFO pointer registers.
  always_ff @(posedge CK_t) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; stale entries are never visible because rd_data is gated by empty.
  always_ff @(posedge CK_t) begin
    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    if (push_en && !reset) mem_q[wr_ptr_q[PTR_W-1:0]] <= word_q;
  end

endmodule

// File: tb/tb_ctrl_rd_capture.sv
// Directed bench for ctrl_rd_capture. Stimulus is a per-edge schedule; the
// expected words and the expected cycles of rd_err/ovf pulses are queued while
// the schedule is built, and a monitor pops and compares them as the DUT
// presents outputs.
module tb_ctrl_rd_capture;

  localparam int N = 300;

  logic        CK_t = 1'b0;
  logic        reset;
  logic        rd_start;
  logic [4:0]  cas_latency;
  logic [1:0]  preamble;
  logic [3:0]  burst_length;
  logic        dqs_t;
  logic        dqs_c;
  logic [7:0]  dq;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        rd_err;
  logic        ovf;

  ctrl_rd_capture dut (
    .CK_t         (CK_t),
    .reset        (reset),
    .rd_start     (rd_start),
    .cas_latency  (cas_latency),
    .preamble     (preamble),
    .burst_length (burst_length),
    .dqs_t        (dqs_t),
    .dqs_c        (dqs_c),
    .dq           (dq),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .rd_err       (rd_err),
    .ovf          (ovf)
  );

  always #5 CK_t = ~CK_t;

  // Schedule: index p is the value sampled at the p-th rising edge.
  logic        s_start [N];
  logic [4:0]  s_cl    [N];
  logic [1:0]  s_pre   [N];
  logic [3:0]  s_bl    [N];
  logic [1:0]  s_dqs   [N];   // 0 idle, 1 preamble (t=1,c=0), 2 both high
  logic [7:0]  s_dq    [N];
  logic        s_rst   [N];
  logic        s_rdy   [N];

  logic [63:0] sb     [$];
  int          err_q  [$];
  int          ovf_q  [$];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  logic [63:0] W [1:6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic apply(input int p);
    if (p < N) begin
      reset        = s_rst[p];
      rd_start     = s_start[p];
      cas_latency  = s_cl[p];
      preamble     = s_pre[p];
      burst_length = s_bl[p];
      dq           = s_dq[p];
      rd_ready     = s_rdy[p];
      dqs_t        = (s_dqs[p] != 2'd0);
      dqs_c        = (s_dqs[p] != 2'd1);
    end else begin
      reset = 1'b0; rd_start = 1'b0; dq = 8'h00; rd_ready = 1'b1;
      dqs_t = 1'b0; dqs_c = 1'b1;
    end
  endtask

  task automatic cmd(input int t, input logic [4:0] cl, input logic [1:0] pre, input logic [3:0] bl);
    s_start[t] = 1'b1;
    s_cl[t]    = cl;
    s_pre[t]   = pre;
    s_bl[t]    = bl;
  endtask

  // Preamble sampled at edge se; beats follow after pre preamble cycles.
  task automatic data(input int se, input int pre, input int nb, input logic [63:0] w);
    s_dqs[se] = 2'd1;
    for (int i = 0; i < nb; i++) s_dq[se + pre + 1 + i] = w[i*8 +: 8];
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge CK_t);
    #2;
  endtask

  always @(posedge CK_t) cyc <= cyc + 1;

  // Driver: inputs for the next edge are set on the falling edge.
  always @(negedge CK_t) apply(cyc + 1);

  // Monitor: compares handshakes and error/overflow pulses against the queues.
  always @(negedge CK_t) begin
    #1;
    if (cyc >= 2) begin
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL word_unexpected cyc=%0d got=%h exp=none", cyc, rd_data);
        end else begin
          check("word", rd_data, sb.pop_front());
        end
      end
      if (rd_err) begin
        if (err_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_err_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          check("rd_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
        end
      end
      if (ovf) begin
        if (ovf_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ovf_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          check("ovf_cycle", 64'(cyc), 64'(ovf_q.pop_front()));
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < N; p++) begin
      s_start[p] = 1'b0; s_cl[p] = 5'd0; s_pre[p] = 2'd1; s_bl[p] = 4'd8;
      s_dqs[p] = 2'd0; s_dq[p] = 8'h00; s_rst[p] = 1'b0; s_rdy[p] = 1'b1;
    end
    s_rst[1] = 1'b1;
    s_rst[2] = 1'b1;

    // A: CL=5, preamble 1, BL8; word at head 16 cycles after the command.
    cmd(5, 5'd5, 2'd1, 4'd8);
    data(11, 1, 8, 64'h8877665544332211);
    sb.push_back(64'h8877665544332211);

    // B: BC4 with a 2-cycle preamble; trailing dq must not leak into the word.
    cmd(30, 5'd3, 2'd2, 4'd4);
    data(34, 2, 4, 64'h00000000D4C3B2A1);
    for (int t = 41; t <= 44; t++) s_dq[t] = 8'hEE;
    sb.push_back(64'h00000000D4C3B2A1);

    // C: no preamble (postamble-like both-high strobe only) -> timeout at 50+4+16.
    cmd(50, 5'd4, 2'd1, 4'd8);
    for (int t = 50; t <= 72; t++) s_dqs[t] = 2'd2;
    err_q.push_back(70);

    // D: consumer stalled, six bursts; fifth overflows, sixth lands on a same-cycle pop.
    W[1] = 64'h0000000014131211; W[2] = 64'h0000000024232221;
    W[3] = 64'h0000000034333231; W[4] = 64'h0000000044434241;
    W[5] = 64'h0000000054535251; W[6] = 64'h0000000064636261;
    for (int t = 80; t <= 149; t++) s_rdy[t] = 1'b0;
    s_rdy[139] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd(80 + 10*k, 5'd2, 2'd1, 4'd4);
      data(83 + 10*k, 1, 4, W[k+1]);
    end
    sb.push_back(W[1]); sb.push_back(W[2]); sb.push_back(W[3]);
    sb.push_back(W[4]); sb.push_back(W[6]);
    ovf_q.push_back(129);

    // E: second command 3 cycles later is queued and served from the latched settings.
    cmd(160, 5'd5, 2'd1, 4'd8);
    cmd(163, 5'd5, 2'd1, 4'd8);
    data(166, 1, 8, 64'h0123456789ABCDEF);
    data(178, 1, 8, 64'hFEDCBA9876543210);
    sb.push_back(64'h0123456789ABCDEF);
    sb.push_back(64'hFEDCBA9876543210);

    // G/F/H: park a word, reset during the 3rd capture beat, then a clean burst.
    for (int t = 195; t <= 230; t++) s_rdy[t] = 1'b0;
    cmd(190, 5'd2, 2'd1, 4'd4);
    data(193, 1, 4, 64'h00000000A5A55A5A);
    cmd(200, 5'd5, 2'd1, 4'd8);
    data(206, 1, 8, 64'hDEADBEEFCAFEF00D);
    s_rst[210] = 1'b1;
    cmd(215, 5'd3, 2'd2, 4'd8);
    data(219, 2, 8, 64'h1122334455667788);
    sb.push_back(64'h1122334455667788);

    // I: four extra commands while busy; three queue, the fourth is dropped.
    cmd(240, 5'd5, 2'd1, 4'd4);
    for (int t = 242; t <= 245; t++) cmd(t, 5'd9, 2'd2, 4'd8);
    err_q.push_back(245);
    data(246, 1, 4, 64'h000000000D0C0B0A);
    data(254, 1, 4, 64'h000000001D1C1B1A);
    data(262, 1, 4, 64'h000000002D2C2B2A);
    data(270, 1, 4, 64'h000000003D3C3B3A);
    sb.push_back(64'h000000000D0C0B0A);
    sb.push_back(64'h000000001D1C1B1A);
    sb.push_back(64'h000000002D2C2B2A);
    sb.push_back(64'h000000003D3C3B3A);

    apply(1);

    at(2);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data",  rd_data,       64'd0);
    check("reset_busy",     64'(busy),     64'd0);
    check("reset_rd_err",   64'(rd_err),   64'd0);
    check("reset_ovf",      64'(ovf),      64'd0);

    at(10);  check("a_busy",        64'(busy),     64'd1);
    at(20);  check("a_valid_early", 64'(rd_valid), 64'd0);
    at(21);  check("a_valid_lat16", 64'(rd_valid), 64'd1);
             check("a_idle",        64'(busy),     64'd0);
    at(41);  check("b_valid_lat11", 64'(rd_valid), 64'd1);

    at(69);  check("c_busy_wait",   64'(busy),     64'd1);
    at(70);  check("c_busy_after",  64'(busy),     64'd0);
             check("c_no_word",     64'(rd_valid), 64'd0);

    at(125); check("d_head_w1",     rd_data,       W[1]);
    at(135); check("d_hold_w1",     rd_data,       W[1]);
    at(140); check("d_head_w2",     rd_data,       W[2]);

    at(170); check("e_pend_1",      64'(dut.pend_q), 64'd1);
    at(177); check("e_pend_0",      64'(dut.pend_q), 64'd0);
             check("e_busy_serve",  64'(busy),       64'd1);
    at(189); check("e_idle",        64'(busy),       64'd0);

    at(205); check("g_parked",      rd_data,       64'h00000000A5A55A5A);
    at(210); check("f_rst_valid",   64'(rd_valid), 64'd0);
             check("f_rst_data",    rd_data,       64'd0);
             check("f_rst_busy",    64'(busy),     64'd0);
    at(229); check("h_valid_early", 64'(rd_valid), 64'd0);
    at(230); check("h_valid",       64'(rd_valid), 64'd1);

    at(246); check("i_pend_sat",    64'(dut.pend_q), 64'd3);
    at(277); check("i_idle",        64'(busy),       64'd0);

    at(290);
    check("sb_drained",  64'(sb.size()),    64'd0);
    check("err_drained", 64'(err_q.size()), 64'd0);
    check("ovf_drained", 64'(ovf_q.size()), 64'd0);
    check("end_valid",   64'(rd_valid),     64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
